// File: rtl/bsram_sim_pkg.sv
// rtl/bsram_sim_pkg.sv - shared constants, sweep state type and byte-lane merge for the single-port BSRAM model
package bsram_sim_pkg;

    localparam int WM_NORMAL            = 0;
    localparam int WM_WRITE_THROUGH     = 1;
    localparam int WM_READ_BEFORE_WRITE = 2;

    localparam int RM_BYPASS   = 0;
    localparam int RM_PIPELINE = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W    = 512;
    localparam int MERGE_BE_W = MERGE_W / 8;

    typedef enum logic [0:0] {
        SW_IDLE  = 1'b0,
        SW_CLEAR = 1'b1
    } sweep_state_t;

    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_word;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bsram_sp_model_if.sv
// rtl/bsram_sp_model_if.sv - access-port bundle of the single-port BSRAM model
interface bsram_sp_model_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);

    logic                  CE;
    logic                  OCE;
    logic                  WRE;
    logic [ADDR_W-1:0]     AD;
    logic [DATA_W/8-1:0]   BE;
    logic [DATA_W-1:0]     DI;
    logic [DATA_W-1:0]     DO;
    logic                  BUSY;

    modport master (
        output CE, OCE, WRE, AD, BE, DI,
        input  DO, BUSY
    );

    modport slave (
        input  CE, OCE, WRE, AD, BE, DI,
        output DO, BUSY
    );

endinterface

// File: rtl/bsram_clear_seq.sv
// rtl/bsram_clear_seq.sv - post-reset array clear sweep: FSM, address counter and BUSY
module bsram_clear_seq #(
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 10,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              busy
);
    import bsram_sim_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    sweep_state_t      state;
    logic              pending;
    logic [ADDR_W-1:0] cnt;

    // The sweep is armed by reset but only starts on the first released edge,
    // so BUSY stays low on every edge at which RESET is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= SW_IDLE;
            pending <= (CLEAR_ON_RESET != 0);
            cnt     <= '0;
        end else begin
            case (state)
                SW_IDLE: begin
                    if (pending) begin
                        state   <= SW_CLEAR;
                        pending <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SW_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= SW_IDLE;
                    end
                    cnt <= cnt + 1'b1;
                end
                default: state <= SW_IDLE;
            endcase
        end
    end

    assign busy     = (state == SW_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/bsram_sp_model.sv
// rtl/bsram_sp_model.sv - parametrised single-port BSRAM behavioural model; BSRAM_SP_XPROP_EN enables X propagation and range errors
module bsram_sp_model #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = 10,
    parameter int READ_MODE      = 0,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    bsram_sp_model_if.slave  bus
);
    import bsram_sim_pkg::*;

    localparam int unsigned DEPTH_U = DEPTH;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] do_q;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] oor_word;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              busy;
    logic              in_range;
    logic              access;

    bsram_clear_seq #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .CLK      (CLK),
        .RESET    (RESET),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy)
    );

`ifdef BSRAM_SP_XPROP_EN
    assign oor_word = 'x;
`else
    assign oor_word = '0;
`endif

    assign in_range = (32'(bus.AD) < DEPTH_U);
    assign access   = bus.CE && !busy && !RESET;

    always_comb begin
        old_word = oor_word;
        if (in_range) begin
            old_word = mem[bus.AD];
        end
        merged = DATA_W'(merge_be(MERGE_W'(old_word), MERGE_W'(bus.DI), MERGE_BE_W'(bus.BE)));
    end

    // The sweep owns the array while BUSY; user writes are simply dropped.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end
`ifdef BSRAM_SP_XPROP_EN
            else if (access && (bus.WRE !== 1'b0) && $isunknown({bus.WRE, bus.BE})
                     && !$isunknown(bus.AD) && in_range) begin
                mem[bus.AD] <= 'x;
            end
`endif
            else if (access && bus.WRE && in_range) begin
                mem[bus.AD] <= merged;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_q <= '0;
        end else if (access) begin
`ifdef BSRAM_SP_XPROP_EN
            if ($isunknown({bus.AD, bus.WRE, bus.BE})) begin
                rd_q <= 'x;
            end else
`endif
            if (!bus.WRE) begin
                rd_q <= old_word;
            end else if (WRITE_MODE == WM_WRITE_THROUGH) begin
                rd_q <= merged;
            end else if (WRITE_MODE == WM_READ_BEFORE_WRITE) begin
                rd_q <= old_word;
            end
        end
    end

    // OCE is deliberately independent of CE so a pipelined read can drain later.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            do_q <= '0;
        end else if (bus.OCE && !busy) begin
            do_q <= rd_q;
        end
    end

`ifdef BSRAM_SP_XPROP_EN
    always_ff @(posedge CLK) begin
        if (access && !$isunknown(bus.AD) && !in_range) begin
            $error("bsram_sp_model: access to address %0d beyond depth %0d", bus.AD, DEPTH);
        end
    end
`endif

    assign bus.DO   = (READ_MODE == RM_PIPELINE) ? do_q : rd_q;
    assign bus.BUSY = busy;

endmodule

// File: tb/tb_bsram_sp_model.sv
// tb/tb_bsram_sp_model.sv - directed self-checking bench for bsram_sp_model across four configurations
module tb_bsram_sp_model;

    logic CLK = 1'b0;
    logic RESET;
    logic RESET3;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bsram_sp_model_if #(.DATA_W(16), .ADDR_W(10)) b0 ();
    bsram_sp_model_if #(.DATA_W(16), .ADDR_W(4))  b1 ();
    bsram_sp_model_if #(.DATA_W(32), .ADDR_W(4))  b2 ();
    bsram_sp_model_if #(.DATA_W(16), .ADDR_W(6))  b3 ();

    bsram_sp_model #(.DATA_W(16), .DEPTH(1000), .ADDR_W(10), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(0))
        u0 (.CLK(CLK), .RESET(RESET), .bus(b0));
    bsram_sp_model #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE(2), .CLEAR_ON_RESET(0))
        u1 (.CLK(CLK), .RESET(RESET), .bus(b1));
    bsram_sp_model #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(1), .CLEAR_ON_RESET(0))
        u2 (.CLK(CLK), .RESET(RESET), .bus(b2));
    bsram_sp_model #(.DATA_W(16), .DEPTH(64), .ADDR_W(6), .READ_MODE(0), .WRITE_MODE(0), .CLEAR_ON_RESET(1))
        u3 (.CLK(CLK), .RESET(RESET3), .bus(b3));

    typedef struct {
        logic        ce;
        logic        wre;
        logic [9:0]  ad;
        logic [1:0]  be;
        logic [15:0] di;
        logic [15:0] exp_do;
    } vec_t;

    vec_t tv [15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b3.BUSY) n++;
            else break;
        end
    endtask

    task automatic drv1(input logic ce, input logic wre, input logic oce, input logic [15:0] di);
        b1.CE = ce; b1.WRE = wre; b1.OCE = oce; b1.AD = 4'd3; b1.BE = 2'b11; b1.DI = di;
    endtask

    task automatic drv3(input logic ce, input logic wre, input logic [5:0] ad, input logic [15:0] di);
        b3.CE = ce; b3.WRE = wre; b3.AD = ad; b3.BE = 2'b11; b3.DI = di;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [5:0] rd_addrs [3];

        RESET = 1'b1; RESET3 = 1'b1;
        b0.CE = 0; b0.OCE = 0; b0.WRE = 0; b0.AD = '0; b0.BE = '0; b0.DI = '0;
        b1.CE = 0; b1.OCE = 0; b1.WRE = 0; b1.AD = '0; b1.BE = '0; b1.DI = '0;
        b2.CE = 0; b2.OCE = 0; b2.WRE = 0; b2.AD = '0; b2.BE = '0; b2.DI = '0;
        b3.CE = 0; b3.OCE = 0; b3.WRE = 0; b3.AD = '0; b3.BE = '0; b3.DI = '0;

        tv[0]  = '{1'b1, 1'b1, 10'd5,    2'b11, 16'hBEEF, 16'h0000};
        tv[1]  = '{1'b1, 1'b0, 10'd5,    2'b11, 16'h0000, 16'hBEEF};
        tv[2]  = '{1'b1, 1'b1, 10'd6,    2'b11, 16'h1234, 16'hBEEF};
        tv[3]  = '{1'b1, 1'b0, 10'd6,    2'b11, 16'h0000, 16'h1234};
        tv[4]  = '{1'b1, 1'b1, 10'd5,    2'b01, 16'hFF00, 16'h1234};
        tv[5]  = '{1'b1, 1'b0, 10'd5,    2'b11, 16'h0000, 16'hBE00};
        tv[6]  = '{1'b0, 1'b0, 10'd6,    2'b11, 16'h0000, 16'hBE00};
        tv[7]  = '{1'b1, 1'b1, 10'd10,   2'b11, 16'h0A0A, 16'hBE00};
        tv[8]  = '{1'b1, 1'b1, 10'd1010, 2'b11, 16'h5A5A, 16'hBE00};
        tv[9]  = '{1'b1, 1'b0, 10'd1010, 2'b11, 16'h0000, 16'h0000};
        tv[10] = '{1'b1, 1'b0, 10'd10,   2'b11, 16'h0000, 16'h0A0A};
        tv[11] = '{1'b1, 1'b1, 10'd999,  2'b11, 16'hC3C3, 16'h0A0A};
        tv[12] = '{1'b1, 1'b0, 10'd999,  2'b11, 16'h0000, 16'hC3C3};
        tv[13] = '{1'b1, 1'b1, 10'd6,    2'b10, 16'hAB99, 16'hC3C3};
        tv[14] = '{1'b1, 1'b0, 10'd6,    2'b11, 16'h0000, 16'hAB34};

        tick(); tick();
        chk("reset_do0",   32'(b0.DO), 32'h0);
        chk("reset_do1",   32'(b1.DO), 32'h0);
        chk("reset_do2",   b2.DO,      32'h0);
        chk("reset_do3",   32'(b3.DO), 32'h0);
        chk("reset_busy3", 32'(b3.BUSY), 32'h0);

        RESET = 1'b0;

        // bypass / normal write mode, including out-of-range and last-word boundary
        for (int i = 0; i < 15; i++) begin
            b0.CE = tv[i].ce; b0.WRE = tv[i].wre; b0.AD = tv[i].ad;
            b0.BE = tv[i].be; b0.DI = tv[i].di;
            tick();
            chk($sformatf("bypass_vec%0d", i), 32'(b0.DO), 32'(tv[i].exp_do));
        end
        b0.CE = 0; b0.WRE = 0;

        // pipelined / read-before-write
        drv1(1, 1, 1, 16'h1111); tick(); chk("pipe_a_reset_out", 32'(b1.DO), 32'h0);
        drv1(1, 1, 1, 16'h2222); tick();
        drv1(0, 0, 1, 16'h0000); tick(); chk("pipe_rbw_old",  32'(b1.DO), 32'h1111);
        drv1(1, 0, 1, 16'h0000); tick(); chk("pipe_hold_lat", 32'(b1.DO), 32'h1111);
        drv1(0, 0, 1, 16'h0000); tick(); chk("pipe_read_new", 32'(b1.DO), 32'h2222);
        drv1(1, 1, 0, 16'h3333); tick();
        drv1(1, 0, 0, 16'h0000); tick(); chk("pipe_oce_hold", 32'(b1.DO), 32'h2222);
        drv1(0, 0, 1, 16'h0000); tick(); chk("pipe_oce_only", 32'(b1.DO), 32'h3333);

        // write-through, 32-bit with byte lanes
        b2.CE = 1; b2.WRE = 1; b2.AD = 4'd7; b2.BE = 4'b1111; b2.DI = 32'hAABBCCDD;
        tick(); chk("wt_full",  b2.DO, 32'hAABBCCDD);
        b2.BE = 4'b0101; b2.DI = 32'h11223344;
        tick(); chk("wt_lanes", b2.DO, 32'hAA22CC44);
        b2.BE = 4'b0000; b2.DI = 32'hFFFFFFFF;
        tick(); chk("wt_no_be", b2.DO, 32'hAA22CC44);
        b2.WRE = 0;
        tick(); chk("wt_read",  b2.DO, 32'hAA22CC44);
        b2.CE = 0;

        // reset leaves the array alone
        RESET = 1'b1; b0.CE = 1; b0.WRE = 0; b0.AD = 10'd5;
        tick(); chk("rst_do0", 32'(b0.DO), 32'h0); chk("rst_do2", b2.DO, 32'h0);
        RESET = 1'b0;
        tick(); chk("rst_keep_mem", 32'(b0.DO), 32'hBE00);
        b0.CE = 0;

        // clear-on-reset sweep
        RESET3 = 1'b0;
        count_busy(n); chk("sweep_len_first", 32'(n), 32'd64);
        drv3(1, 1, 6'd0,  16'h1111); tick();
        drv3(1, 1, 6'd20, 16'h2020); tick();
        drv3(1, 1, 6'd63, 16'h6363); tick();
        drv3(1, 0, 6'd63, 16'h0000); tick(); chk("prefill_63", 32'(b3.DO), 32'h6363);
        RESET3 = 1'b1;
        tick(); chk("sweep_rst_do", 32'(b3.DO), 32'h0); chk("sweep_rst_busy", 32'(b3.BUSY), 32'h0);
        RESET3 = 1'b0;
        drv3(1, 1, 6'd20, 16'hFFFF);
        for (int i = 0; i < 20; i++) tick();
        chk("sweep_mid_busy", 32'(b3.BUSY), 32'h1);
        RESET3 = 1'b1;
        tick(); chk("abort_do", 32'(b3.DO), 32'h0); chk("abort_busy", 32'(b3.BUSY), 32'h0);
        RESET3 = 1'b0;
        count_busy(n); chk("sweep_len_restart", 32'(n), 32'd64);
        drv3(0, 0, 6'd0, 16'h0000);
        rd_addrs[0] = 6'd0; rd_addrs[1] = 6'd20; rd_addrs[2] = 6'd63;
        for (int i = 0; i < 3; i++) begin
            drv3(1, 0, rd_addrs[i], 16'h0000);
            tick();
            chk($sformatf("cleared_%0d", rd_addrs[i]), 32'(b3.DO), 32'h0);
        end
        b3.CE = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
